cva6_ptw_sv32_lite: RTL and testbench
=====================================

Name: cva6_ptw_sv32_lite

Overview:
- Sv32 page-table walker sitting directly upstream of cva6_tlb_sv32.
- Accepts a TLB miss (vaddr + ASID) and walks the two-level Sv32 table over a simple req/gnt/rvalid memory port.
- Emits a single-cycle 63-bit update packet that connects straight to the TLB's update_i.
- Reports page faults with a one-cycle error pulse; never updates the TLB on a fault.

Parameters:
- ASID_WIDTH, 9, width of the miss ASID input; zero-extended into the fixed 9-bit packet field.
- PLEN, 34, physical address width of mem_addr_o.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- satp_ppn_i  in  22  root page-table PPN
- miss_valid_i  in  1  TLB miss request
- miss_ready_o  out  1  walker can accept a miss (IDLE only)
- miss_vaddr_i  in  32  faulting virtual address
- miss_asid_i  in  ASID_WIDTH  ASID of miss
- flush_i  in  1  abort current walk (sfence)
- mem_req_o  out  1  PTE read request
- mem_addr_o  out  PLEN  PTE byte address
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  PTE data
- tlb_update_o  out  63  {valid[62], is_4M[61], vpn[60:41], asid[40:32], content[31:0]}
- walk_error_o  out  1  one-cycle page-fault pulse
- busy_o  out  1  walk in progress (state != IDLE)

Behaviour:
- Reset: state=IDLE; all outputs 0 except miss_ready_o=1; internal kill flag=0.
- States and transitions:
  - IDLE: miss_ready_o=1. On miss_valid_i, latch vaddr/asid and go to L1_REQ.
  - L1_REQ: mem_req_o=1, mem_addr_o = satp_ppn_i*4096 + vpn[19:10]*4 (PLEN bits). Go to L1_WAIT on mem_gnt_i.
  - L1_WAIT: on mem_rvalid_i, decode the PTE:
    - invalid (V=0, or R=0&&W=1) -> FAULT
    - leaf (R|X) with pte[19:10]!=0 -> FAULT (misaligned superpage)
    - leaf otherwise -> UPDATE with is_4M=1
    - non-leaf -> L0_REQ, next ppn = pte[31:10]
  - L0_REQ: address = ppn*4096 + vpn[9:0]*4; same gnt rule.
  - L0_WAIT: on rvalid, invalid or non-leaf -> FAULT; otherwise UPDATE with is_4M=0.
  - UPDATE: tlb_update_o valid for exactly 1 cycle, content = raw leaf PTE; then IDLE.
  - FAULT: walk_error_o=1 for 1 cycle, tlb_update_o=0; then IDLE.
- tlb_update_o is 0 in every state except UPDATE.
- Handshake: once mem_req_o rises, it and mem_addr_o stay stable until mem_gnt_i. Exactly one outstanding read at a time; rvalid is only expected after gnt.
- Latency with zero-wait memory (gnt same cycle as req, rvalid the next cycle):
  - 4K page: update 5 cycles after miss acceptance.
  - 4M page: update 3 cycles after miss acceptance.
- flush_i:
  - In IDLE: ignored.
  - In any REQ/WAIT state: set kill. The in-flight transaction still completes (gnt, then rvalid is absorbed). On that rvalid go to IDLE with no update and no error.
  - flush_i and miss_valid_i in the same IDLE cycle: the miss is accepted.
- satp_ppn_i is sampled at L1_REQ entry only.
- rst_i mid-walk forces IDLE immediately. The memory side must tolerate a dropped request.

Optional Feature:
- Macro: CVA6_PTW_PERF_CNT_EN.
- Defined: adds output walk_cnt_o[31:0] and fault_cnt_o[31:0]. walk_cnt_o increments on each UPDATE, fault_cnt_o on each FAULT. Both wrap at 2^32 and clear on rst_i.
- Undefined: these ports and their counters do not exist.

Decomposition:
- Package cva6_ptw_sv32_pkg holds:
  - state enum
  - pte_t struct (ppn1[31:20], ppn0[19:10], rsw, D, A, G, U, X, W, R, V)
  - tlb_update_t packed struct matching the 63-bit layout
  - constants PTE_SIZE=4 and PAGE_SHIFT=12
- One sub-module, cva6_ptw_pte_check: combinational PTE classification (invalid, leaf, misaligned) shared by both levels.

Test Plan:
- 4K walk: satp_ppn=0x80, vaddr 0x12345000, asid 1.
  - Expect L1 addr 0x80120. Return 0x00020001.
  - Expect L0 addr 0x80D14. Return 0x0400000F.
  - Expect update {1,0,0x12345,1,0x0400000F}, 5 cycles after acceptance.
- Superpage: vaddr 0x40000000, expect L1 addr 0x80400. Return 0x2000000B -> update {1,1,0x40000,asid,0x2000000B}.
- Misaligned superpage: return 0x2000040B at L1 -> walk_error_o one pulse, tlb_update_o stays 0.
- Invalid PTE: L1 PTE 0x00000000 -> fault. Non-leaf at L0 (0x00020001) -> fault.
- Flush mid-walk: assert flush_i in L1_WAIT, then rvalid -> no update, no error, IDLE.
- Backpressure: hold mem_gnt_i low for 3 cycles -> mem_req_o and mem_addr_o stable throughout. Repeat with rst_i asserted mid-walk -> IDLE next cycle with miss_ready_o=1.

Source files
------------

// File: rtl/cva6_ptw_sv32_pkg.sv
// Shared types and constants for the Sv32 page-table walker: walker states,
// the Sv32 PTE layout and the 63-bit TLB update packet.
package cva6_ptw_sv32_pkg;

  localparam int PTE_SIZE   = 4;
  localparam int PAGE_SHIFT = 12;

  typedef enum logic [2:0] {
    IDLE,
    L1_REQ,
    L1_WAIT,
    L0_REQ,
    L0_WAIT,
    UPDATE,
    FAULT
  } state_e;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  typedef struct packed {
    logic        valid;
    logic        is_4m;
    logic [19:0] vpn;
    logic [8:0]  asid;
    logic [31:0] content;
  } tlb_update_t;

  // Byte address of entry idx in the page-table page numbered ppn.
  function automatic logic [33:0] pte_addr(logic [21:0] ppn, logic [9:0] idx);
    return (34'(ppn) << PAGE_SHIFT) + (34'(idx) << $clog2(PTE_SIZE));
  endfunction

endpackage

// File: rtl/cva6_ptw_pte_check.sv
// Combinational Sv32 PTE classification, shared by both walk levels.
module cva6_ptw_pte_check
  import cva6_ptw_sv32_pkg::*;
(
  input  logic [31:0] pte,
  output logic        invalid,
  output logic        leaf,
  output logic        misaligned
);

  pte_t p;
  logic unused_bits;

  assign p           = pte_t'(pte);
  assign invalid     = !p.v || (!p.r && p.w);
  assign leaf        = p.r || p.x;
  // Only meaningful at level 1: a superpage must have ppn0 == 0.
  assign misaligned  = leaf && (p.ppn0 != '0);
  assign unused_bits = ^{p.ppn1, p.rsw, p.d, p.a, p.g, p.u};

endmodule

// File: rtl/cva6_ptw_sv32_lite.sv
// Sv32 two-level page-table walker feeding cva6_tlb_sv32 update_i.
// Optional perf counters (walk_cnt_o/fault_cnt_o) under CVA6_PTW_PERF_CNT_EN.
module cva6_ptw_sv32_lite
  import cva6_ptw_sv32_pkg::*;
#(
  parameter int ASID_WIDTH = 9,
  parameter int PLEN       = 34
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [21:0]           satp_ppn_i,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [31:0]           miss_vaddr_i,
  input  logic [ASID_WIDTH-1:0] miss_asid_i,
  input  logic                  flush_i,
  output logic                  mem_req_o,
  output logic [PLEN-1:0]       mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic [62:0]           tlb_update_o,
  output logic                  walk_error_o,
  output logic                  busy_o
`ifdef CVA6_PTW_PERF_CNT_EN
  ,
  output logic [31:0]           walk_cnt_o,
  output logic [31:0]           fault_cnt_o
`endif
);

  state_e                state_q, state_d;
  logic [19:0]           vpn_q;
  logic [ASID_WIDTH-1:0] asid_q;
  logic [21:0]           ppn_q;
  logic [31:0]           pte_q;
  logic                  is_4m_q;
  logic                  kill_q;
  logic                  kill;
  logic                  pte_invalid, pte_leaf, pte_misaligned;

  assign kill = kill_q | flush_i;

  cva6_ptw_pte_check u_pte_check (
    .pte        (mem_rdata_i),
    .invalid    (pte_invalid),
    .leaf       (pte_leaf),
    .misaligned (pte_misaligned)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss_valid_i) state_d = L1_REQ;
      L1_REQ:  if (mem_gnt_i) state_d = L1_WAIT;
      L1_WAIT: if (mem_rvalid_i) begin
        if (kill)                              state_d = IDLE;
        else if (pte_invalid || pte_misaligned) state_d = FAULT;
        else if (pte_leaf)                     state_d = UPDATE;
        else                                   state_d = L0_REQ;
      end
      L0_REQ:  if (mem_gnt_i) state_d = L0_WAIT;
      L0_WAIT: if (mem_rvalid_i) begin
        if (kill)                         state_d = IDLE;
        else if (pte_invalid || !pte_leaf) state_d = FAULT;
        else                              state_d = UPDATE;
      end
      UPDATE:  state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A flush during a walk only marks it killed; the outstanding read still
  // has to drain before returning to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vpn_q   <= '0;
      asid_q  <= '0;
      ppn_q   <= '0;
      pte_q   <= '0;
      is_4m_q <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      if (state_d == IDLE) kill_q <= 1'b0;
      else if (flush_i && (state_q inside {L1_REQ, L1_WAIT, L0_REQ, L0_WAIT})) kill_q <= 1'b1;

      if (state_q == IDLE && miss_valid_i) begin
        vpn_q  <= miss_vaddr_i[31:12];
        asid_q <= miss_asid_i;
        ppn_q  <= satp_ppn_i;
      end else if (state_q == L1_WAIT && mem_rvalid_i) begin
        pte_q   <= mem_rdata_i;
        ppn_q   <= mem_rdata_i[31:10];
        is_4m_q <= 1'b1;
      end else if (state_q == L0_WAIT && mem_rvalid_i) begin
        pte_q   <= mem_rdata_i;
        is_4m_q <= 1'b0;
      end
    end
  end

  always_comb begin
    miss_ready_o = 1'b0;
    busy_o       = 1'b1;
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    tlb_update_o = '0;
    walk_error_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        miss_ready_o = 1'b1;
        busy_o       = 1'b0;
      end
      L1_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = PLEN'(pte_addr(ppn_q, vpn_q[19:10]));
      end
      L0_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = PLEN'(pte_addr(ppn_q, vpn_q[9:0]));
      end
      UPDATE: tlb_update_o = tlb_update_t'{valid: 1'b1, is_4m: is_4m_q, vpn: vpn_q,
                                           asid: 9'(asid_q), content: pte_q};
      FAULT:  walk_error_o = 1'b1;
      default: ;
    endcase
  end

`ifdef CVA6_PTW_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      walk_cnt_o  <= '0;
      fault_cnt_o <= '0;
    end else begin
      if (state_q == UPDATE) walk_cnt_o  <= walk_cnt_o + 32'd1;
      if (state_q == FAULT)  fault_cnt_o <= fault_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cva6_ptw_sv32_lite.sv
// Self-checking bench for cva6_ptw_sv32_lite: directed walks plus randomized
// walks against a behavioural Sv32 model. Counter checks under CVA6_PTW_PERF_CNT_EN.
module tb_cva6_ptw_sv32_lite;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [21:0] satp_ppn_i;
  logic        miss_valid_i;
  logic        miss_ready_o;
  logic [31:0] miss_vaddr_i;
  logic [8:0]  miss_asid_i;
  logic        flush_i;
  logic        mem_req_o;
  logic [33:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [62:0] tlb_update_o;
  logic        walk_error_o;
  logic        busy_o;
`ifdef CVA6_PTW_PERF_CNT_EN
  logic [31:0] walk_cnt_o;
  logic [31:0] fault_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_walks = 0;
  int exp_faults = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  cva6_ptw_sv32_lite #(.ASID_WIDTH(9), .PLEN(34)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .satp_ppn_i   (satp_ppn_i),
    .miss_valid_i (miss_valid_i),
    .miss_ready_o (miss_ready_o),
    .miss_vaddr_i (miss_vaddr_i),
    .miss_asid_i  (miss_asid_i),
    .flush_i      (flush_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .tlb_update_o (tlb_update_o),
    .walk_error_o (walk_error_o),
    .busy_o       (busy_o)
`ifdef CVA6_PTW_PERF_CNT_EN
    ,
    .walk_cnt_o   (walk_cnt_o),
    .fault_cnt_o  (fault_cnt_o)
`endif
  );

  // Drives one miss and acts as the memory; returns what was observed.
  task automatic do_walk(input logic [21:0] satp, input logic [31:0] va, input logic [8:0] asid,
                         input logic [31:0] pte1, input logic [31:0] pte0,
                         input int gd1, input int gd0, input int flush_read, input bit flush_accept,
                         output int nreads, output logic [33:0] a1, output logic [33:0] a2,
                         output logic [62:0] upd, output int nupd, output int nerr,
                         output int lat, output bit stable_ok, output bit timeout);
    int c0;
    int steps;
    int gd;
    logic [33:0] addr;
    nreads = 0; a1 = '0; a2 = '0; upd = '0; nupd = 0; nerr = 0;
    lat = -1; stable_ok = 1'b1; timeout = 1'b0; steps = 0;
    satp_ppn_i = satp; miss_vaddr_i = va; miss_asid_i = asid;
    miss_valid_i = 1'b1; flush_i = flush_accept;
    c0 = cyc;
    @(negedge clk_i);
    miss_valid_i = 1'b0; flush_i = 1'b0;
    while (miss_ready_o !== 1'b1) begin
      if (steps > 40 || nreads > 2) begin timeout = 1'b1; break; end
      steps++;
      if (tlb_update_o !== '0) begin upd = tlb_update_o; nupd++; if (lat < 0) lat = cyc - c0; end
      if (walk_error_o === 1'b1) begin nerr++; if (lat < 0) lat = cyc - c0; end
      if (mem_req_o === 1'b1) begin
        nreads++;
        addr = mem_addr_o;
        if (nreads == 1) a1 = addr; else a2 = addr;
        gd = (nreads == 1) ? gd1 : gd0;
        repeat (gd) begin
          @(negedge clk_i);
          if (mem_req_o !== 1'b1 || mem_addr_o !== addr) stable_ok = 1'b0;
        end
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        if (flush_read == nreads) begin
          flush_i = 1'b1;
          @(negedge clk_i);
          flush_i = 1'b0;
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = (nreads == 1) ? pte1 : pte0;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
      end else begin
        @(negedge clk_i);
      end
    end
    if (tlb_update_o !== '0) nupd++;
    if (walk_error_o === 1'b1) nerr++;
  endtask

  // Reference model: Sv32 walk rules expressed as plain arithmetic.
  task automatic model_walk(input logic [21:0] satp, input logic [31:0] va, input logic [8:0] asid,
                            input logic [31:0] p1, input logic [31:0] p0,
                            output int nr, output logic [33:0] e1, output logic [33:0] e2,
                            output logic [62:0] eu, output bit efault);
    nr = 1; e2 = '0; eu = '0; efault = 1'b0;
    e1 = 34'(64'(satp) * 4096 + 64'(va >> 22) * 4);
    if (!p1[0] || (!p1[1] && p1[2])) efault = 1'b1;
    else if (p1[1] || p1[3]) begin
      if (((p1 >> 10) & 32'h3FF) != 32'h0) efault = 1'b1;
      else eu = {1'b1, 1'b1, va[31:12], asid, p1};
    end else begin
      nr = 2;
      e2 = 34'(64'(p1 >> 10) * 4096 + 64'((va >> 12) & 32'h3FF) * 4);
      if (!p0[0] || (!p0[1] && p0[2]) || !(p0[1] || p0[3])) efault = 1'b1;
      else eu = {1'b1, 1'b0, va[31:12], asid, p0};
    end
  endtask

  function automatic logic [31:0] gen_pte(input bit level1);
    logic [31:0] p;
    p = $urandom;
    case ($urandom_range(0, 3))
      0: p[3:0] = 4'b0001;
      1: begin p[3:0] = 4'b1011; if (level1) p[19:10] = '0; end
      2: p[3:0] = 4'b0111;
      default: ;
    endcase
    return p;
  endfunction

  task automatic test_reset();
    rst_i = 1'b1; miss_valid_i = 1'b1; flush_i = 1'b0; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; satp_ppn_i = '0; miss_vaddr_i = '0; miss_asid_i = '0;
    repeat (3) @(negedge clk_i);
    checks++; if (miss_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", miss_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if ({mem_req_o, mem_addr_o} !== 35'h0) begin errors++; $display("[TB] FAIL reset_mem: got %b/%h expected 0/0", mem_req_o, mem_addr_o); end
    checks++; if ({tlb_update_o, walk_error_o} !== 64'h0) begin errors++; $display("[TB] FAIL reset_outputs: got %h/%b expected 0/0", tlb_update_o, walk_error_o); end
    miss_valid_i = 1'b0; rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_walk_4k();
    int nr, nu, ne, lat; logic [33:0] a1, a2; logic [62:0] upd; bit st, to;
    do_walk(22'h80, 32'h12345000, 9'd1, 32'h00020001, 32'h0400000F, 0, 0, 0, 1'b0,
            nr, a1, a2, upd, nu, ne, lat, st, to);
    exp_walks++;
    checks++; if (to) begin errors++; $display("[TB] FAIL walk4k_timeout: got timeout expected completion"); end
    checks++; if (a1 !== 34'h80120) begin errors++; $display("[TB] FAIL walk4k_l1_addr: got %h expected 80120", a1); end
    checks++; if (a2 !== 34'h80D14) begin errors++; $display("[TB] FAIL walk4k_l0_addr: got %h expected 80d14", a2); end
    checks++; if (upd !== {1'b1, 1'b0, 20'h12345, 9'd1, 32'h0400000F} || nu != 1) begin errors++; $display("[TB] FAIL walk4k_update: got %h x%0d expected %h x1", upd, nu, {1'b1, 1'b0, 20'h12345, 9'd1, 32'h0400000F}); end
    checks++; if (lat != 5) begin errors++; $display("[TB] FAIL walk4k_latency: got %0d expected 5", lat); end
    checks++; if (ne != 0) begin errors++; $display("[TB] FAIL walk4k_error: got %0d pulses expected 0", ne); end
  endtask

  task automatic test_superpage();
    int nr, nu, ne, lat; logic [33:0] a1, a2; logic [62:0] upd; bit st, to;
    do_walk(22'h80, 32'h40000000, 9'h1A5, 32'h2000000B, 32'h0, 0, 0, 0, 1'b0,
            nr, a1, a2, upd, nu, ne, lat, st, to);
    exp_walks++;
    checks++; if (a1 !== 34'h80400 || nr != 1) begin errors++; $display("[TB] FAIL super_l1: got %h reads %0d expected 80400 reads 1", a1, nr); end
    checks++; if (upd !== {1'b1, 1'b1, 20'h40000, 9'h1A5, 32'h2000000B} || nu != 1) begin errors++; $display("[TB] FAIL super_update: got %h x%0d expected %h x1", upd, nu, {1'b1, 1'b1, 20'h40000, 9'h1A5, 32'h2000000B}); end
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL super_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_misaligned();
    int nr, nu, ne, lat; logic [33:0] a1, a2; logic [62:0] upd; bit st, to;
    do_walk(22'h80, 32'h40000000, 9'd2, 32'h2000040B, 32'h0, 0, 0, 0, 1'b0,
            nr, a1, a2, upd, nu, ne, lat, st, to);
    exp_faults++;
    checks++; if (ne != 1) begin errors++; $display("[TB] FAIL misaligned_error: got %0d pulses expected 1", ne); end
    checks++; if (nu != 0) begin errors++; $display("[TB] FAIL misaligned_update: got %0d updates expected 0", nu); end
  endtask

  task automatic test_invalid();
    int nr, nu, ne, lat; logic [33:0] a1, a2; logic [62:0] upd; bit st, to;
    do_walk(22'h80, 32'h12345000, 9'd3, 32'h00000000, 32'h0, 0, 0, 0, 1'b0,
            nr, a1, a2, upd, nu, ne, lat, st, to);
    exp_faults++;
    checks++; if (ne != 1 || nu != 0 || nr != 1) begin errors++; $display("[TB] FAIL invalid_l1: got err %0d upd %0d reads %0d expected 1 0 1", ne, nu, nr); end
    checks++; if (lat != 3) begin errors++; $display("[TB] FAIL invalid_l1_latency: got %0d expected 3", lat); end
    do_walk(22'h80, 32'h12345000, 9'd3, 32'h00020001, 32'h00020001, 0, 0, 0, 1'b0,
            nr, a1, a2, upd, nu, ne, lat, st, to);
    exp_faults++;
    checks++; if (ne != 1 || nu != 0 || a2 !== 34'h80D14) begin errors++; $display("[TB] FAIL nonleaf_l0: got err %0d upd %0d addr %h expected 1 0 80d14", ne, nu, a2); end
  endtask

  task automatic test_flush();
    int nr, nu, ne, lat; logic [33:0] a1, a2; logic [62:0] upd; bit st, to;
    do_walk(22'h80, 32'h12345000, 9'd1, 32'h00020001, 32'h0400000F, 0, 0, 1, 1'b0,
            nr, a1, a2, upd, nu, ne, lat, st, to);
    checks++; if (nu != 0 || ne != 0 || nr != 1) begin errors++; $display("[TB] FAIL flush_l1wait: got upd %0d err %0d reads %0d expected 0 0 1", nu, ne, nr); end
    checks++; if (to || miss_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL flush_idle: got ready %b timeout %b expected 1 0", miss_ready_o, to); end
    do_walk(22'h80, 32'h12345000, 9'd1, 32'h00020001, 32'h0400000F, 0, 0, 0, 1'b1,
            nr, a1, a2, upd, nu, ne, lat, st, to);
    exp_walks++;
    checks++; if (upd !== {1'b1, 1'b0, 20'h12345, 9'd1, 32'h0400000F} || nu != 1) begin errors++; $display("[TB] FAIL flush_with_miss: got %h x%0d expected accepted walk", upd, nu); end
  endtask

  task automatic test_backpressure();
    int nr, nu, ne, lat; logic [33:0] a1, a2; logic [62:0] upd; bit st, to;
    do_walk(22'h80, 32'h12345000, 9'd1, 32'h00020001, 32'h0400000F, 3, 3, 0, 1'b0,
            nr, a1, a2, upd, nu, ne, lat, st, to);
    exp_walks++;
    checks++; if (!st) begin errors++; $display("[TB] FAIL backpressure_stable: got unstable req/addr expected stable"); end
    checks++; if (lat != 11 || a1 !== 34'h80120) begin errors++; $display("[TB] FAIL backpressure_latency: got %0d addr %h expected 11 80120", lat, a1); end
  endtask

  task automatic test_reset_mid_walk();
    int nr, nu, ne, lat; logic [33:0] a1, a2; logic [62:0] upd; bit st, to;
    satp_ppn_i = 22'h80; miss_vaddr_i = 32'h12345000; miss_asid_i = 9'd1; miss_valid_i = 1'b1;
    @(negedge clk_i);
    miss_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 34'h80120) begin errors++; $display("[TB] FAIL rstmid_req: got %b/%h expected 1/80120", mem_req_o, mem_addr_o); end
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++; if (miss_ready_o !== 1'b1 || busy_o !== 1'b0 || mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_idle: got ready %b busy %b req %b expected 1 0 0", miss_ready_o, busy_o, mem_req_o); end
    rst_i = 1'b0;
    exp_walks = 0; exp_faults = 0;
    @(negedge clk_i);
    do_walk(22'h80, 32'h40000000, 9'd7, 32'h2000000B, 32'h0, 0, 0, 0, 1'b0,
            nr, a1, a2, upd, nu, ne, lat, st, to);
    exp_walks++;
    checks++; if (upd !== {1'b1, 1'b1, 20'h40000, 9'd7, 32'h2000000B}) begin errors++; $display("[TB] FAIL rstmid_recover: got %h expected %h", upd, {1'b1, 1'b1, 20'h40000, 9'd7, 32'h2000000B}); end
  endtask

  task automatic test_random();
    int nr, nu, ne, lat, enr, exp_reads, gd1, gd0, fr, explat;
    logic [33:0] a1, a2, e1, e2; logic [62:0] upd, eu; bit st, to, efault, flushed;
    logic [21:0] satp; logic [31:0] va, p1, p0; logic [8:0] asid;
    for (int i = 0; i < 150; i++) begin
      satp = 22'($urandom); va = $urandom; asid = 9'($urandom_range(0, 511));
      p1 = gen_pte(1'b1); p0 = gen_pte(1'b0);
      gd1 = $urandom_range(0, 3); gd0 = $urandom_range(0, 3);
      fr = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
      model_walk(satp, va, asid, p1, p0, enr, e1, e2, eu, efault);
      flushed = (fr != 0) && (fr <= enr);
      exp_reads = flushed ? fr : enr;
      explat = 1 + 2 * enr + gd1 + ((enr == 2) ? gd0 : 0);
      do_walk(satp, va, asid, p1, p0, gd1, gd0, fr, 1'b0, nr, a1, a2, upd, nu, ne, lat, st, to);
      checks++; if (to || nr != exp_reads) begin errors++; $display("[TB] FAIL rand_reads[%0d]: got %0d timeout %b expected %0d", i, nr, to, exp_reads); end
      checks++; if (a1 !== e1) begin errors++; $display("[TB] FAIL rand_l1_addr[%0d]: got %h expected %h", i, a1, e1); end
      if (exp_reads == 2) begin
        checks++; if (a2 !== e2) begin errors++; $display("[TB] FAIL rand_l0_addr[%0d]: got %h expected %h", i, a2, e2); end
      end
      checks++; if (!st) begin errors++; $display("[TB] FAIL rand_stable[%0d]: got unstable expected stable", i); end
      if (flushed) begin
        checks++; if (nu != 0 || ne != 0) begin errors++; $display("[TB] FAIL rand_flush[%0d]: got upd %0d err %0d expected 0 0", i, nu, ne); end
      end else if (efault) begin
        exp_faults++;
        checks++; if (ne != 1 || nu != 0 || lat != explat) begin errors++; $display("[TB] FAIL rand_fault[%0d]: got err %0d upd %0d lat %0d expected 1 0 %0d", i, ne, nu, lat, explat); end
      end else begin
        exp_walks++;
        checks++; if (upd !== eu || nu != 1 || ne != 0 || lat != explat) begin errors++; $display("[TB] FAIL rand_update[%0d]: got %h x%0d err %0d lat %0d expected %h x1 0 %0d", i, upd, nu, ne, lat, eu, explat); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_walk_4k();
    test_superpage();
    test_misaligned();
    test_invalid();
    test_flush();
    test_backpressure();
    test_reset_mid_walk();
    test_random();
`ifdef CVA6_PTW_PERF_CNT_EN
    checks++; if (walk_cnt_o !== 32'(exp_walks)) begin errors++; $display("[TB] FAIL walk_cnt: got %0d expected %0d", walk_cnt_o, exp_walks); end
    checks++; if (fault_cnt_o !== 32'(exp_faults)) begin errors++; $display("[TB] FAIL fault_cnt: got %0d expected %0d", fault_cnt_o, exp_faults); end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
